// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming asynchronous PWM waveform in i_ce sample ticks.
// Reports {period, high} of the last completed period as one 2*ROM_WIDTH word.
// Optional build macro PWM_CAPTURE_GLITCH_FILTER_EN inserts a 3-sample
// majority/hold filter between the synchronizer and the sampled level.
module pwm_capture #(
   parameter int ROM_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_ce,
   input  logic                   i_pwm,
   output logic [2*ROM_WIDTH-1:0] o_data,
   output logic                   o_valid,
   output logic                   o_stuck,
   output logic                   o_level
);

   localparam logic [ROM_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [ROM_WIDTH-1:0] CNT_ONE = ROM_WIDTH'(1);

   typedef enum logic {ARM, MEAS} state_t;

   state_t               state;
   logic                 sync_p0;
   logic                 sync_p1;
   logic                 s;
   logic                 samp;
   logic                 rise;
   logic [ROM_WIDTH-1:0] per_cnt;
   logic [ROM_WIDTH-1:0] high_cnt;
   logic [ROM_WIDTH-1:0] per_nxt;

   // Saturating increment: never wraps past the all-ones value.
   function automatic logic [ROM_WIDTH-1:0] sat_inc(input logic [ROM_WIDTH-1:0] v,
                                                    input logic inc);
      if (inc && (v != CNT_MAX))
         return v + CNT_ONE;
      return v;
   endfunction

   // Two-flop synchronizer for the asynchronous PWM input, runs every clk.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= i_pwm;
         sync_p1 <= sync_p0;
      end
   end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   logic [1:0] flt_hist;

   // Keeps the two previous raw samples; the level only moves when three agree.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         flt_hist <= 2'b00;
      else if (i_ce)
         flt_hist <= {flt_hist[0], sync_p1};
   end

   assign samp = ((sync_p1 == flt_hist[0]) && (sync_p1 == flt_hist[1])) ? sync_p1 : s;
`else
   assign samp = sync_p1;
`endif

   // A rising sample: the value being taken is high while the held level is low.
   assign rise    = i_ce & samp & ~s;
   assign per_nxt = sat_inc(per_cnt, 1'b1);
   assign o_level = s;

   // Measurement FSM: arms on the first rising sample, then reports each full period.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ARM;
         s        <= 1'b0;
         per_cnt  <= '0;
         high_cnt <= '0;
         o_data   <= '0;
         o_valid  <= 1'b0;
         o_stuck  <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if (i_ce) begin
            s <= samp;
            if (state == ARM) begin
               if (rise) begin
                  per_cnt  <= CNT_ONE;
                  high_cnt <= CNT_ONE;
                  state    <= MEAS;
               end
            end else begin
               if (rise) begin
                  o_data   <= {per_cnt, high_cnt};
                  o_valid  <= 1'b1;
                  o_stuck  <= 1'b0;
                  per_cnt  <= CNT_ONE;
                  high_cnt <= CNT_ONE;
               end else if (per_nxt == CNT_MAX) begin
                  // No rising edge for a full counter range: flag and re-arm.
                  o_stuck  <= 1'b1;
                  per_cnt  <= '0;
                  high_cnt <= '0;
                  state    <= ARM;
               end else begin
                  per_cnt  <= per_nxt;
                  high_cnt <= sat_inc(high_cnt, samp);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed and randomized PWM patterns against pwm_capture.
// Expected words come from the pattern itself: {period/div, high/div} in samples.
module tb_pwm_capture;

   localparam int W = 8;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int LAT = 4;
   localparam bit FILT = 1'b1;
`else
   localparam int LAT = 2;
   localparam bit FILT = 1'b0;
`endif

   logic           clk   = 1'b0;
   logic           rst   = 1'b1;
   logic           i_ce  = 1'b0;
   logic           i_pwm = 1'b0;
   logic [2*W-1:0] o_data;
   logic           o_valid;
   logic           o_stuck;
   logic           o_level;

   int n_pass  = 0;
   int n_total = 0;
   int edge_n  = 0;

   pwm_capture #(.ROM_WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_ce    (i_ce),
      .i_pwm   (i_pwm),
      .o_data  (o_data),
      .o_valid (o_valid),
      .o_stuck (o_stuck),
      .o_level (o_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Drive one clk worth of input, then sample 1 ns after the rising edge.
   task automatic step(input logic pwm, input logic ce);
      i_pwm = pwm;
      i_ce  = ce;
      @(posedge clk);
      edge_n++;
      #1;
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_data"},  o_data,  32'd0);
      chk({tag, "_valid"}, o_valid, 32'd0);
      chk({tag, "_stuck"}, o_stuck, 32'd0);
      chk({tag, "_level"}, o_level, 32'd0);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b0;
      #1;
      check_cleared(tag);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      rst = 1'b1;
   endtask

   // Ps/Hs are in samples; the waveform uses Ps*div and Hs*div clocks.
   task automatic run_pwm(input int Ps, input int Hs, input int div, input int nper,
                          input bit glitch, input bit chk_data,
                          output int nvalid, output int nbad, output int last_start);
      logic [2*W-1:0] expd;
      logic           hist[$];
      logic           lvl;
      int             k;
      int             pc;
      int             hc;
      expd       = {W'(Ps), W'(Hs)};
      pc         = Ps * div;
      hc         = Hs * div;
      nvalid     = 0;
      nbad       = 0;
      last_start = 0;
      k          = 0;
      for (int i = 0; i < LAT; i++) hist.push_back(1'b0);
      for (int p = 0; p < nper; p++) begin
         for (int j = 0; j < pc; j++) begin
            lvl = (j < hc);
            if (glitch && ((k % 7) == 0) &&
                (((j >= 3) && (j <= hc - 4)) || ((j >= hc + 3) && (j <= pc - 4))))
               lvl = ~lvl;
            if (j == 0) last_start = edge_n + 1;
            hist.push_back(lvl);
            step(lvl, (k % div) == 0);
            k++;
            if ((div == 1) && !glitch)
               chk("level", o_level, hist[hist.size() - 1 - LAT]);
            if (o_valid) begin
               nvalid++;
               if (chk_data) chk("data", o_data, expd);
               else if (o_data !== expd) nbad++;
            end
         end
      end
   endtask

   initial begin
      int nv;
      int nb;
      int ls;
      int rise_e;
      int dv;
      int ps;
      int hs;

      // Power-on reset
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      check_cleared("por");
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      rst = 1'b1;

      // Period 10 / high 3, i_ce every clk
      run_pwm(10, 3, 1, 6, 1'b0, 1'b1, nv, nb, ls);
      chk("p10h3_nvalid", nv, 32'd5);

      // i_ce every 4th clk: period 40 / high 20 clk -> 10 / 5 samples
      do_reset("rst_b");
      run_pwm(10, 5, 4, 4, 1'b0, 1'b1, nv, nb, ls);
      chk("ce4_nvalid", nv, 32'd3);

      // Randomized patterns
      for (int t = 0; t < 4; t++) begin
         dv = $urandom_range(2, 1);
         ps = $urandom_range(60, 8);
         hs = $urandom_range(ps - 3, 3);
         do_reset("rst_rnd");
         run_pwm(ps, hs, dv, 4, 1'b0, 1'b1, nv, nb, ls);
         chk("rnd_nvalid", nv, 32'd3);
      end

      // Longest reportable period
      do_reset("rst_254");
      run_pwm(254, 100, 1, 3, 1'b0, 1'b1, nv, nb, ls);
      chk("p254_nvalid", nv, 32'd2);
      chk("p254_stuck", o_stuck, 32'd0);

      // Period equal to the saturation value never reports
      do_reset("rst_255");
      run_pwm(255, 100, 1, 3, 1'b0, 1'b1, nv, nb, ls);
      chk("p255_nvalid", nv, 32'd0);
      chk("p255_stuck", o_stuck, 32'd1);
      chk("p255_data", o_data, 32'd0);

      // Lock, then hold the input low until stuck
      do_reset("rst_stuck");
      run_pwm(10, 3, 1, 3, 1'b0, 1'b1, nv, nb, ls);
      chk("prestuck_nvalid", nv, 32'd2);
      rise_e = ls + LAT;
      for (int i = 0; i < 300; i++) begin
         step(1'b0, 1'b1);
         chk("stuck", o_stuck, 32'(edge_n >= rise_e + 254));
         chk("stuck_novalid", o_valid, 32'd0);
      end
      chk("stuck_data_held", o_data, {16'd0, 8'd10, 8'd3});
      chk("stuck_level", o_level, 32'd0);
      run_pwm(10, 3, 1, 3, 1'b0, 1'b1, nv, nb, ls);
      chk("restore_nvalid", nv, 32'd2);
      chk("restore_stuck", o_stuck, 32'd0);

      // Reset pulsed during the high phase, released in the low phase
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      rst = 1'b0;
      #1;
      check_cleared("midrst");
      for (int j = 2; j < 10; j++) begin
         if (j == 8) rst = 1'b1;
         step(j < 3, 1'b1);
         chk("midrst_novalid", o_valid, 32'd0);
      end
      run_pwm(10, 3, 1, 3, 1'b0, 1'b1, nv, nb, ls);
      chk("midrst_nvalid", nv, 32'd2);

      // One-clk glitches every 7 clk on a period-20 waveform
      do_reset("rst_glitch");
      run_pwm(20, 10, 1, 8, 1'b1, FILT, nv, nb, ls);
      if (FILT) chk("glitch_nvalid", nv, 32'd7);
      else      chk("glitch_spurious", 32'(nb > 0), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the team's PWM controller: measures an incoming PWM waveform.
- Reports period and high time as one 2*ROM_WIDTH word, same packing as the controller's data input: upper half period, lower half high time.
- Used for loop-back checking of the controller and for reading external PWM sensors.
- Input is asynchronous to clk; all timing is counted in i_ce sample ticks.

Parameters:
- ROM_WIDTH, 8, width of each measured field; counters saturate at 2^ROM_WIDTH-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately.
- i_ce  input  1  sample enable; counting and edge detection advance only on clk cycles with i_ce=1.
- i_pwm  input  1  asynchronous PWM input.
- o_data  output  2*ROM_WIDTH  {period, high}, in sample ticks, from the last completed period.
- o_valid  output  1  one-clk pulse when o_data updates.
- o_stuck  output  1  no rising edge seen for 2^ROM_WIDTH-1 samples; level-held.
- o_level  output  1  current sampled input level.

Behaviour:
- Reset (rst=0) values:
  - o_data=0, o_valid=0, o_stuck=0, o_level=0.
  - Synchronizer flops 0, counters 0, state ARM.
- Synchronizer: 2-flop on every clk. Its output is sampled into s on i_ce cycles only; s_prev holds the previous sample. o_level=s.
- Rising sample: i_ce=1 and sync=1 and s=0 (the sample being taken is high, the previous was low).
- Input-to-s latency: 2 clk plus wait for next i_ce.
- States:
  - ARM: wait for the first rising sample. Counters are held at 0 and o_valid is never asserted. On a rising sample: per_cnt<=1, high_cnt<=1, go to MEAS.
  - MEAS, rising sample: o_data<={per_cnt, high_cnt}, o_valid=1 next clk, o_stuck<=0, then per_cnt<=1, high_cnt<=1.
  - MEAS, other i_ce cycle: per_cnt<=sat(per_cnt+1); high_cnt<=sat(high_cnt+sampled level).
  - MEAS, saturation: per_cnt reaching 2^ROM_WIDTH-1 sets o_stuck=1 and returns to ARM. o_data keeps its last value.
- i_ce=0 cycles: no state change except the synchronizer; o_valid deasserts after its one-clk pulse.
- Arithmetic: unsigned, saturating, never wrapping.
- high_cnt never exceeds per_cnt. high=0 cannot be reported, because a period always starts high.
- 100% duty (constant high) or 0% (constant low): no rising edge, so o_stuck after saturation; o_level gives the level.
- Reset mid-measurement: everything clears at once, and the next period measured after reset is discarded (ARM).
- o_valid is registered; o_data changes on the same edge that o_valid rises.

Optional Feature:
- Macro PWM_CAPTURE_GLITCH_FILTER_EN.
- Defined:
  - A 3-sample majority/hold filter sits between the synchronizer and s.
  - s changes only after 3 consecutive i_ce samples agree on the new level; pulses shorter than 3 samples are ignored.
  - Latency increases by 2 samples. Period and high values are unchanged for clean input.
- Undefined: s takes the synchronizer output directly on each i_ce.

Test Plan:
- Reset, i_ce=1 every clk, PWM of period 10 clk with high 3 clk -> first valid at the second rising edge, o_data={8'd10,8'd3}; repeats every 10 clk.
- i_ce every 4th clk, PWM period 40 clk with high 20 clk -> o_data={8'd10,8'd5}.
- i_pwm held low for 300 samples after lock -> o_stuck=1 at 255 samples, o_data holds last value, o_level=0; restore PWM -> first rising edge only re-arms, next period gives valid and o_stuck=0.
- rst pulsed low mid-high-phase -> all outputs 0 immediately; no o_valid until one full period after release.
- Drive 1-clk glitches every 7 clk on a period-20 PWM (i_ce=1):
  - with PWM_CAPTURE_GLITCH_FILTER_EN: o_data={8'd20, high} unaffected;
  - without it: spurious short periods reported.
- Loop-back with the team's PWM controller at several data words -> captured o_data equals the programmed word.
